clock_display_scan: RTL and testbench
=====================================

CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot (>=4).
REQ-002 Parameter BLANK_CYC, default 2, cycles at the start of each slot with all anodes off (ghost suppression; < SCAN_DIV).
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 upd  in  1  single-cycle strobe: sec/min/hr valid, capture now.
REQ-006 sec  in  6  seconds, binary, legal 0..59.
REQ-007 min  in  6  minutes, binary, legal 0..59.
REQ-008 hr   in  5  hours, binary, legal 0..23.
REQ-009 an   out 6  digit enables, active-low; bit0 = sec units ... bit5 = hr tens.
REQ-010 seg  out 7  segments gfedcba, active-low.
REQ-011 dp   out 1  decimal point/colon, active-low.

Function
REQ-012 When upd=1, sec/min/hr SHALL be captured into shadow registers; the display SHALL use only the shadow values (no tearing).
REQ-013 Each shadow value SHALL be converted to two BCD digits (tens, units); conversion SHALL be visible on seg no later than 2 cycles after capture, provided that digit is the active one.
REQ-014 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance 0,1,2,3,4,5,0 (wrap 5->0).
REQ-015 While prescaler < BLANK_CYC, an SHALL be 6'b111111; otherwise exactly one an bit (the digit index) SHALL be 0.
REQ-016 seg SHALL be a registered output, 1-cycle latency from the digit index/shadow value; an and seg SHALL change in the same cycle.
REQ-017 Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Out-of-range shadow value (sec>59, min>59, hr>23) SHALL show dash 0111111 on both digits of that field; other fields unaffected.
REQ-019 Hour tens digit equal to 0 SHALL be blanked (seg=1111111) while an still cycles.
REQ-020 upd asserted during blanking or mid-slot SHALL take effect in the current slot; the prescaler and digit index SHALL not be disturbed.

Reset
REQ-021 With rst=0 at a clock edge: an=111111, seg=1111111, dp=1, prescaler=0, digit index=0, shadows=0; upd SHALL be ignored.
REQ-022 Reset asserted mid-slot SHALL take effect on the next edge; after release, the first active digit SHALL be index 0 at prescaler=BLANK_CYC.

Configuration
REQ-023 Macro CLOCK_DISPLAY_COLON_EN: when defined, dp SHALL be 0 (lit) on digits 2 and 4 when shadow sec is even and 1 otherwise (1 Hz colon blink); when undefined, dp SHALL be constantly 1.

Structure
REQ-024 Shared package clock_disp_pkg SHALL hold the segment-code constants (digits 0-9, dash, blank), the field limits (59, 23), and the digit-index enum.
REQ-025 Sub-module bin2bcd_2d (6-bit binary in, tens/units BCD out, range flag) SHALL be instantiated once per field.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-026 Reset, then upd with sec=7, min=45, hr=13 -> slots show 7,0,5,4,3,1 on an bits 0..5; an=111111 for 2 cycles per slot.
REQ-027 hr=5 -> hr tens slot gives an[5]=0 and seg=1111111; hr units slot gives 0010010.
REQ-028 sec=60 -> digits 0 and 1 show 0111111; min/hr digits correct.
REQ-029 upd issued mid-slot on digit 2, min changing 45->46 -> seg switches from 0010010 to 0000010 within 2 cycles; digit index unchanged.
REQ-030 rst=0 at prescaler=5 of digit 3 -> next edge: an=111111, seg=1111111; after release, digit 0 first enabled on cycle 2.
REQ-031 With CLOCK_DISPLAY_COLON_EN, sec=8 -> dp=0 on slots 2 and 4 only; sec=9 -> dp=1 throughout; macro undefined -> dp=1 always.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// ============================================================================
// Module : clock_disp_pkg
// Brief  : Segment codes, field limits and digit-slot enum for the clock scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clock_disp_pkg;

  // Segment patterns are gfedcba, active-low
  localparam logic [6:0] C_SEG_0     = 7'b1000000;
  localparam logic [6:0] C_SEG_1     = 7'b1111001;
  localparam logic [6:0] C_SEG_2     = 7'b0100100;
  localparam logic [6:0] C_SEG_3     = 7'b0110000;
  localparam logic [6:0] C_SEG_4     = 7'b0011001;
  localparam logic [6:0] C_SEG_5     = 7'b0010010;
  localparam logic [6:0] C_SEG_6     = 7'b0000010;
  localparam logic [6:0] C_SEG_7     = 7'b1111000;
  localparam logic [6:0] C_SEG_8     = 7'b0000000;
  localparam logic [6:0] C_SEG_9     = 7'b0010000;
  localparam logic [6:0] C_SEG_DASH  = 7'b0111111;
  localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

  localparam int C_SEC_MAX = 59;
  localparam int C_MIN_MAX = 59;
  localparam int C_HR_MAX  = 23;

  typedef enum logic [2:0] {
    DIG_SEC_U = 3'd0,
    DIG_SEC_T = 3'd1,
    DIG_MIN_U = 3'd2,
    DIG_MIN_T = 3'd3,
    DIG_HR_U  = 3'd4,
    DIG_HR_T  = 3'd5
  } digit_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = C_SEG_0;
      4'd1:    code = C_SEG_1;
      4'd2:    code = C_SEG_2;
      4'd3:    code = C_SEG_3;
      4'd4:    code = C_SEG_4;
      4'd5:    code = C_SEG_5;
      4'd6:    code = C_SEG_6;
      4'd7:    code = C_SEG_7;
      4'd8:    code = C_SEG_8;
      4'd9:    code = C_SEG_9;
      default: code = C_SEG_DASH;
    endcase
    return code;
  endfunction

  function automatic digit_e next_digit(input digit_e d);
    return (d == DIG_HR_T) ? DIG_SEC_U : digit_e'(d + 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_2d.sv
// ============================================================================
// Module : bin2bcd_2d
// Brief  : 6-bit binary to two BCD digits with an above-LIMIT range flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_2d
  import clock_disp_pkg::*;
#(
  parameter int LIMIT = C_SEC_MAX
) (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       oor_o
);

  logic [2:0] w_tens;
  logic [5:0] w_rem;

  // Subtractive compare chain: values never exceed 63, so tens is at most 6
  always_comb begin
    w_tens = 3'd0;
    w_rem  = bin_i;
    if (bin_i >= 6'd60) begin
      w_tens = 3'd6;
      w_rem  = bin_i - 6'd60;
    end else if (bin_i >= 6'd50) begin
      w_tens = 3'd5;
      w_rem  = bin_i - 6'd50;
    end else if (bin_i >= 6'd40) begin
      w_tens = 3'd4;
      w_rem  = bin_i - 6'd40;
    end else if (bin_i >= 6'd30) begin
      w_tens = 3'd3;
      w_rem  = bin_i - 6'd30;
    end else if (bin_i >= 6'd20) begin
      w_tens = 3'd2;
      w_rem  = bin_i - 6'd20;
    end else if (bin_i >= 6'd10) begin
      w_tens = 3'd1;
      w_rem  = bin_i - 6'd10;
    end
  end

  assign tens_o  = {1'b0, w_tens};
  assign units_o = 4'(w_rem);
  assign oor_o   = (bin_i > 6'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/clock_display_scan.sv
// ============================================================================
// Module : clock_display_scan
// Brief  : Six-digit HH:MM:SS multiplexed 7-segment scanner with ghost blanking.
//          Optional colon blink on digits 2/4 via macro CLOCK_DISPLAY_COLON_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  digit_e        idx_q, idx_d;
  logic [5:0]    sec_q, min_q;
  logic [4:0]    hr_q;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0] w_sec_t, w_sec_u, w_min_t, w_min_u, w_hr_t, w_hr_u;
  logic       w_sec_oor, w_min_oor, w_hr_oor;

  bin2bcd_2d #(.LIMIT(C_SEC_MAX)) u_sec_bcd (
    .bin_i  (sec_q),
    .tens_o (w_sec_t),
    .units_o(w_sec_u),
    .oor_o  (w_sec_oor)
  );

  bin2bcd_2d #(.LIMIT(C_MIN_MAX)) u_min_bcd (
    .bin_i  (min_q),
    .tens_o (w_min_t),
    .units_o(w_min_u),
    .oor_o  (w_min_oor)
  );

  bin2bcd_2d #(.LIMIT(C_HR_MAX)) u_hr_bcd (
    .bin_i  ({1'b0, hr_q}),
    .tens_o (w_hr_t),
    .units_o(w_hr_u),
    .oor_o  (w_hr_oor)
  );

  // Outputs are registered from the next scan position so an/seg line up with the prescaler
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = next_digit(idx_q);
    end

    if (presc_d < PW'(BLANK_CYC)) begin
      an_d = 6'b111111;
    end else begin
      an_d = ~(6'b000001 << idx_d);
    end

    case (idx_d)
      DIG_SEC_U: seg_d = w_sec_oor ? C_SEG_DASH : seg_encode(w_sec_u);
      DIG_SEC_T: seg_d = w_sec_oor ? C_SEG_DASH : seg_encode(w_sec_t);
      DIG_MIN_U: seg_d = w_min_oor ? C_SEG_DASH : seg_encode(w_min_u);
      DIG_MIN_T: seg_d = w_min_oor ? C_SEG_DASH : seg_encode(w_min_t);
      DIG_HR_U:  seg_d = w_hr_oor  ? C_SEG_DASH : seg_encode(w_hr_u);
      DIG_HR_T:  seg_d = w_hr_oor  ? C_SEG_DASH :
                         (w_hr_t == 4'd0) ? C_SEG_BLANK : seg_encode(w_hr_t);
      default:   seg_d = C_SEG_BLANK;
    endcase

`ifdef CLOCK_DISPLAY_COLON_EN
    dp_d = !(((idx_d == DIG_MIN_U) || (idx_d == DIG_HR_U)) && !sec_q[0]);
`else
    dp_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= DIG_SEC_U;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      an_q    <= 6'b111111;
      seg_q   <= C_SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (upd) begin
        sec_q <= sec;
        min_q <= min;
        hr_q  <= hr;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_display_scan.sv
// ============================================================================
// Module : tb_clock_display_scan
// Brief  : Self-checking bench for clock_display_scan (SCAN_DIV=8, BLANK_CYC=2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_clock_display_scan;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       upd = 1'b0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hr  = '0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .upd(upd), .sec(sec), .min(min), .hr(hr),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Behavioural model: position derived from edges since reset release
  int         m_sec, m_min, m_hr, m_n, mp, md;
  bit         m_valid = 1'b0;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] c;
    case (d)
      0: c = 7'b1000000;  1: c = 7'b1111001;  2: c = 7'b0100100;
      3: c = 7'b0110000;  4: c = 7'b0011001;  5: c = 7'b0010010;
      6: c = 7'b0000010;  7: c = 7'b1111000;  8: c = 7'b0000000;
      default: c = 7'b0010000;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] m_digit_seg(input int d);
    int v, lim, dig;
    v   = (d < 2) ? m_sec : (d < 4) ? m_min : m_hr;
    lim = (d < 4) ? 59 : 23;
    if (v > lim) return 7'b0111111;
    dig = (d % 2 == 0) ? v % 10 : v / 10;
    if (d == 5 && dig == 0) return 7'b1111111;
    return seg_of(dig);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1'b1;
      m_n = 0; m_sec = 0; m_min = 0; m_hr = 0;
      e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
    end else if (m_valid) begin
      m_n++;
      mp = m_n % SCAN_DIV;
      md = (m_n / SCAN_DIV) % 6;
      e_an  = (mp < BLANK_CYC) ? 6'h3F : ~(6'b000001 << md);
      e_seg = m_digit_seg(md);
      e_dp  = 1'b1;
`ifdef CLOCK_DISPLAY_COLON_EN
      if ((md == 2 || md == 4) && (m_sec % 2 == 0)) e_dp = 1'b0;
`endif
      if (upd) begin
        m_sec = sec; m_min = min; m_hr = hr;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (an !== e_an) begin
        n_fail++;
        $display("FAIL model_an t=%0t got %b expected %b", $time, an, e_an);
      end
      n_checks++;
      if (seg !== e_seg) begin
        n_fail++;
        $display("FAIL model_seg t=%0t got %b expected %b", $time, seg, e_seg);
      end
      n_checks++;
      if (dp !== e_dp) begin
        n_fail++;
        $display("FAIL model_dp t=%0t got %b expected %b", $time, dp, e_dp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic wait_slot(input int d);
    int k;
    k = 0;
    @(negedge clk);
    while (an !== ~(6'b000001 << d) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_slot%0d timeout an=%b", d, an);
    end
  endtask

  task automatic do_upd(input int s, input int m, input int h);
    sec = 6'(s); min = 6'(m); hr = 5'(h); upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
  endtask

  logic [6:0] lit [6];
  int         order [6];

  initial begin
    lit[0] = 7'b1111000; lit[1] = 7'b1000000; lit[2] = 7'b0010010;
    lit[3] = 7'b0011001; lit[4] = 7'b0110000; lit[5] = 7'b1111001;
    order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 4; order[4] = 5; order[5] = 0;

    rst = 1'b0;
    upd = 1'b1; sec = 6'd33; min = 6'd33; hr = 5'd11;
    repeat (3) @(negedge clk);
    upd = 1'b0;
    chk("reset_an", 32'(an), 32'h3F);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);

    rst = 1'b1;
    @(negedge clk);
    chk("release_c1_an", 32'(an), 32'h3F);
    @(negedge clk);
    chk("release_c2_an", 32'(an), 32'h3E);
    chk("release_c2_seg", 32'(seg), 32'b1000000);

    // 13:45:07 walked across all slots
    do_upd(7, 45, 13);
    chk("t1307_d0", 32'(seg), 32'(lit[0]));
    for (int i = 0; i < 6; i++) begin
      wait_slot(order[i]);
      chk($sformatf("t1307_d%0d", order[i]), 32'(seg), 32'(lit[order[i]]));
    end

    do_upd(7, 45, 5);
    wait_slot(4);
    chk("hr5_units", 32'(seg), 32'b0010010);
    wait_slot(5);
    chk("hr5_tens_an", 32'(an), 32'b011111);
    chk("hr5_tens_blank", 32'(seg), 32'b1111111);

    do_upd(60, 45, 13);
    wait_slot(0);
    chk("sec60_d0", 32'(seg), 32'b0111111);
    wait_slot(1);
    chk("sec60_d1", 32'(seg), 32'b0111111);
    wait_slot(2);
    chk("sec60_d2", 32'(seg), 32'b0010010);
    wait_slot(5);
    chk("sec60_d5", 32'(seg), 32'b1111001);

    do_upd(7, 45, 13);
    wait_slot(2);
    chk("midslot_before", 32'(seg), 32'b0010010);
    @(negedge clk);
    min = 6'd46; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
    chk("midslot_after", 32'(seg), 32'b0000010);
    chk("midslot_an", 32'(an), 32'b111011);

`ifdef CLOCK_DISPLAY_COLON_EN
    do_upd(8, 45, 13);
    wait_slot(2);
    chk("colon_even_d2", 32'(dp), 32'h0);
    wait_slot(3);
    chk("colon_even_d3", 32'(dp), 32'h1);
    wait_slot(4);
    chk("colon_even_d4", 32'(dp), 32'h0);
    do_upd(9, 45, 13);
    wait_slot(2);
    chk("colon_odd_d2", 32'(dp), 32'h1);
`else
    do_upd(8, 45, 13);
    wait_slot(2);
    chk("nocolon_d2", 32'(dp), 32'h1);
    wait_slot(4);
    chk("nocolon_d4", 32'(dp), 32'h1);
`endif

    // Reset at prescaler 5 of digit 3
    wait_slot(2);
    wait_slot(3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_an", 32'(an), 32'h3F);
    chk("midreset_seg", 32'(seg), 32'h7F);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_c1_an", 32'(an), 32'h3F);
    @(negedge clk);
    chk("midreset_c2_an", 32'(an), 32'h3E);
    chk("midreset_c2_seg", 32'(seg), 32'b1000000);

    for (int c = 0; c < 3000; c++) begin
      upd = 1'b0;
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        upd = 1'b1;
        sec = 6'($urandom_range(0, 63));
        min = 6'($urandom_range(0, 63));
        hr  = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
    end
    rst = 1'b1;
    upd = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
